accel_seq_ctrl: RTL and testbench

- Host-side sequencer for the MNIST NN accelerator. It collects the 785-word image vector (bias word plus 784 pixels) from the PicoRV32 bus one word per write and presents it as the flat image bus.
- It then kicks the accelerator, waits for the accelerator to report completion, and runs a serial signed argmax over the 10 class scores.
- It sits between the core's memory-mapped interface and the accelerator top, replacing direct core control of the accelerator's reset and ready signals.

---
 rtl/accel_pkg.sv | 21 ++
 rtl/accel_seq_ctrl_argmax_serial.sv | 43 ++++
 rtl/accel_seq_ctrl.sv | 119 +++++++++++
 tb/tb_accel_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants and state encoding for the MNIST accelerator host sequencer.
package accel_pkg;

    localparam int N_WORDS = 785;
    localparam int N_CLASS = 10;
    localparam int WORD_W  = 32;
    localparam int CLS_W   = $clog2(N_CLASS);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        FULL,
        KICK,
        BLANK,
        WAIT,
        ARGMAX,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/accel_seq_ctrl_argmax_serial.sv
// Serial signed argmax: one score per cycle, strict greater-than so ties keep the lower index.
module argmax_serial
    import accel_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic                     last,
    input  logic signed [WORD_W-1:0] score,
    input  logic        [CLS_W-1:0]  idx,
    output logic signed [WORD_W-1:0] best_score,
    output logic        [CLS_W-1:0]  best_idx,
    output logic                     valid
);

    logic signed [WORD_W-1:0] run_score;
    logic        [CLS_W-1:0]  run_idx;

    // best_* already includes the current sample, so the result is usable in the last cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        best_score = run_score;
        best_idx   = run_idx;
        if (start || (score > run_score)) begin
            best_score = score;
            best_idx   = idx;
        end
    end

    assign valid = en && last;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_score <= '0;
            run_idx   <= '0;
        end else if (en) begin
            run_score <= best_score;
            run_idx   <= best_idx;
        end
    end

endmodule

// File: rtl/accel_seq_ctrl.sv
// Host-side sequencer: gathers the image from the bus, kicks the accelerator, waits, then argmaxes the scores.
module accel_seq_ctrl
    import accel_pkg::*;
#(
    parameter int KICK_CYC  = 2,
    parameter int BLANK_CYC = 4,
    parameter int TIMEOUT   = 200000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       host_wr_valid,
    input  logic [WORD_W-1:0]          host_wr_data,
    output logic                       host_wr_ready,
    input  logic                       host_start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [CLS_W-1:0]           pred_class,
    output logic [WORD_W-1:0]          pred_score,
    output logic [N_WORDS*WORD_W-1:0]  accel_image,
    output logic                       accel_reset,
    input  logic                       accel_ready,
    input  logic [N_CLASS*WORD_W-1:0]  accel_results
);

    localparam int WC_W    = $clog2(N_WORDS + 1);
    localparam int TMR_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int MAX_KB  = (KICK_CYC > BLANK_CYC) ? KICK_CYC : BLANK_CYC;
    localparam int CNT_MAX = (MAX_KB > N_CLASS) ? MAX_KB : N_CLASS;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    state_t                   state, state_nxt;
    logic [WC_W-1:0]          wcnt;
    logic [CNT_W-1:0]         cnt;
    logic [TMR_W-1:0]         timer;
    logic                     accept;
    logic signed [WORD_W-1:0] am_score, best_score;
    logic [CLS_W-1:0]         best_idx;
    logic                     am_en, am_start, am_last, am_valid;

    assign accept   = host_wr_valid && host_wr_ready;
    assign am_en    = (state == ARGMAX);
    assign am_start = (cnt == '0);
    assign am_last  = (cnt == CNT_W'(N_CLASS - 1));
    assign am_score = accel_results[int'(cnt)*WORD_W +: WORD_W];

    argmax_serial u_argmax (
        .clk        (clk),
        .reset      (reset),
        .en         (am_en),
        .start      (am_start),
        .last       (am_last),
        .score      (am_score),
        .idx        (CLS_W'(cnt)),
        .best_score (best_score),
        .best_idx   (best_idx),
        .valid      (am_valid)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: if (accept) state_nxt = LOAD;
            LOAD:   if (accept && (wcnt == WC_W'(N_WORDS - 1))) state_nxt = FULL;
            FULL:   if (host_start) state_nxt = KICK;
            KICK:   if (cnt == CNT_W'(KICK_CYC - 1)) state_nxt = BLANK;
            BLANK:  if (cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = WAIT;
            WAIT: begin
                if (accel_ready)                          state_nxt = ARGMAX;
                else if (timer == TMR_W'(TIMEOUT - 1))    state_nxt = ERR;
            end
            ARGMAX: if (am_valid) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the image buffer is a wide register, not a RAM, so clearing it on reset is legitimate.
            state         <= IDLE;
            wcnt          <= '0;
            cnt           <= '0;
            timer         <= '0;
            accel_image   <= '0;
            host_wr_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            accel_reset   <= 1'b0;
            pred_class    <= '0;
            pred_score    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            state         <= state_nxt;
            host_wr_ready <= state_nxt inside {IDLE, LOAD, DONE, ERR};
            busy          <= state_nxt inside {KICK, BLANK, WAIT, ARGMAX};
            accel_reset   <= (state_nxt == KICK);
            cnt           <= (state_nxt != state) ? '0 : cnt + 1'b1;
            timer         <= (state != WAIT) ? '0 : timer + 1'b1;

            if (accept) begin
                accel_image <= {host_wr_data, accel_image[N_WORDS*WORD_W-1:WORD_W]};
                wcnt        <= (state == LOAD) ? wcnt + 1'b1 : WC_W'(1);
                done        <= 1'b0;
                error       <= 1'b0;
            end

            if ((state == ARGMAX) && (state_nxt == DONE)) begin
                pred_class <= best_idx;
                pred_score <= best_score;
                done       <= 1'b1;
            end

            if ((state == WAIT) && (state_nxt == ERR)) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Directed bench for accel_seq_ctrl: loads images, models the accelerator handshake and checks results.
module tb_accel_seq_ctrl;
    import accel_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      host_wr_valid;
    logic [31:0]               host_wr_data;
    logic                      host_wr_ready;
    logic                      host_start;
    logic                      busy, done, error;
    logic [CLS_W-1:0]          pred_class;
    logic [31:0]               pred_score;
    logic [N_WORDS*32-1:0]     accel_image;
    logic                      accel_reset;
    logic                      accel_ready;
    logic [N_CLASS*32-1:0]     accel_results;

    int tests = 0;
    int fails = 0;

    accel_seq_ctrl #(.KICK_CYC(2), .BLANK_CYC(4), .TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .host_wr_valid (host_wr_valid),
        .host_wr_data  (host_wr_data),
        .host_wr_ready (host_wr_ready),
        .host_start    (host_start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .pred_class    (pred_class),
        .pred_score    (pred_score),
        .accel_image   (accel_image),
        .accel_reset   (accel_reset),
        .accel_ready   (accel_ready),
        .accel_results (accel_results)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int base, input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            host_wr_valid = 1'b1;
            host_wr_data  = 32'(base + k);
            step();
        end
        host_wr_valid = 1'b0;
    endtask

    task automatic set_scores(input int s [N_CLASS]);
        for (int k = 0; k < N_CLASS; k++) accel_results[k*32 +: 32] = 32'(s[k]);
    endtask

    // mode 0: ready drops at kick and rises 50 cycles later; 1: always high; 2: never high.
    task automatic run(input int mode, output int lat, output int kicks);
        int k;
        k = 0;
        lat = 0;
        kicks = 0;
        accel_ready = (mode != 2);
        host_start = 1'b1;
        while (lat < 500 && !done && !error) begin
            step();
            host_start = 1'b0;
            lat++;
            if (accel_reset) kicks++;
            if (mode == 0) begin
                if (accel_reset) begin
                    accel_ready = 1'b0;
                    k = 0;
                end else begin
                    k++;
                    if (k >= 50) accel_ready = 1'b1;
                end
            end
        end
        tests++;
        if (!done && !error) begin
            $display("FAIL run_budget: no done/error after %0d cycles", lat);
            fails++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests += 7;
        if (host_wr_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", host_wr_ready); fails++; end
        if (busy !== 1'b0)          begin $display("FAIL rst_busy: got %b want 0", busy); fails++; end
        if (done !== 1'b0)          begin $display("FAIL rst_done: got %b want 0", done); fails++; end
        if (error !== 1'b0)         begin $display("FAIL rst_error: got %b want 0", error); fails++; end
        if (accel_reset !== 1'b0)   begin $display("FAIL rst_accel_reset: got %b want 0", accel_reset); fails++; end
        if (pred_class !== '0 || pred_score !== '0) begin
            $display("FAIL rst_pred: got %0d/%0d want 0/0", pred_class, pred_score); fails++;
        end
        if (accel_image !== '0)     begin $display("FAIL rst_image: buffer not zero"); fails++; end
    endtask

    task automatic test_normal();
        int lat, kicks;
        load_words(100, 0, N_WORDS);
        tests += 3;
        if (accel_image[31:0] !== 32'd100) begin
            $display("FAIL img_word0: got %0d want 100", accel_image[31:0]); fails++;
        end
        if (accel_image[25119:25088] !== 32'd884) begin
            $display("FAIL img_word784: got %0d want 884", accel_image[25119:25088]); fails++;
        end
        if (host_wr_ready !== 1'b0) begin $display("FAIL full_ready: got %b want 0", host_wr_ready); fails++; end
        set_scores('{-5, 3, 9, 9, -1, 0, 2, 1, 8, 7});
        run(0, lat, kicks);
        tests += 6;
        if (lat !== 63)          begin $display("FAIL norm_latency: got %0d want 63", lat); fails++; end
        if (kicks !== 2)         begin $display("FAIL norm_kick_len: got %0d want 2", kicks); fails++; end
        if (pred_class !== 4'd2) begin $display("FAIL norm_class: got %0d want 2", pred_class); fails++; end
        if (pred_score !== 32'd9) begin $display("FAIL norm_score: got %0d want 9", $signed(pred_score)); fails++; end
        if (done !== 1'b1 || error !== 1'b0) begin
            $display("FAIL norm_flags: got done=%b error=%b want 1/0", done, error); fails++;
        end
        if (busy !== 1'b0)       begin $display("FAIL norm_busy: got %b want 0", busy); fails++; end
    endtask

    task automatic test_premature_overflow();
        load_words(1000, 0, 400);
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        step();
        step();
        tests += 3;
        if (busy !== 1'b0 || accel_reset !== 1'b0) begin
            $display("FAIL early_start: got busy=%b accel_reset=%b want 0/0", busy, accel_reset); fails++;
        end
        if (host_wr_ready !== 1'b1) begin $display("FAIL early_ready: got %b want 1", host_wr_ready); fails++; end
        if (done !== 1'b0)          begin $display("FAIL reload_clears_done: got %b want 0", done); fails++; end
        load_words(1000, 400, N_WORDS - 400);
        host_wr_valid = 1'b1;
        host_wr_data  = 32'hDEAD_BEEF;
        step();
        host_wr_valid = 1'b0;
        tests += 4;
        if (host_wr_ready !== 1'b0) begin $display("FAIL ovf_ready: got %b want 0", host_wr_ready); fails++; end
        if (accel_image[31:0] !== 32'd1000) begin
            $display("FAIL ovf_word0: got %0d want 1000", accel_image[31:0]); fails++;
        end
        if (accel_image[25119:25088] !== 32'd1784) begin
            $display("FAIL ovf_word784: got %0d want 1784", accel_image[25119:25088]); fails++;
        end
        if (busy !== 1'b0) begin $display("FAIL ovf_busy: got %b want 0", busy); fails++; end
    endtask

    task automatic test_stale_ready();
        int lat, kicks;
        set_scores('{0, -1, 5, 4, 5, 2, -8, 3, 1, 6});
        run(1, lat, kicks);
        tests += 3;
        if (lat !== 18)           begin $display("FAIL stale_latency: got %0d want 18", lat); fails++; end
        if (pred_class !== 4'd9)  begin $display("FAIL stale_class: got %0d want 9", pred_class); fails++; end
        if (pred_score !== 32'd6) begin $display("FAIL stale_score: got %0d want 6", $signed(pred_score)); fails++; end
    endtask

    task automatic test_all_negative();
        int lat, kicks;
        load_words(7, 0, 1);
        tests++;
        if (done !== 1'b0) begin $display("FAIL write_clears_done: got %b want 0", done); fails++; end
        load_words(7, 1, N_WORDS - 1);
        set_scores('{-9, -3, -3, -7, -4, -6, -5, -10, -11, -8});
        run(0, lat, kicks);
        tests += 3;
        if (lat !== 63)          begin $display("FAIL neg_latency: got %0d want 63", lat); fails++; end
        if (pred_class !== 4'd1) begin $display("FAIL neg_class: got %0d want 1", pred_class); fails++; end
        if (pred_score !== 32'hFFFF_FFFD) begin
            $display("FAIL neg_score: got %0d want -3", $signed(pred_score)); fails++;
        end
    endtask

    task automatic test_timeout();
        int lat, kicks;
        load_words(0, 0, N_WORDS);
        set_scores('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        run(2, lat, kicks);
        tests += 4;
        if (lat !== 71) begin $display("FAIL tmo_latency: got %0d want 71", lat); fails++; end
        if (error !== 1'b1 || done !== 1'b0) begin
            $display("FAIL tmo_flags: got error=%b done=%b want 1/0", error, done); fails++;
        end
        if (busy !== 1'b0) begin $display("FAIL tmo_busy: got %b want 0", busy); fails++; end
        if (pred_class !== 4'd1 || pred_score !== 32'hFFFF_FFFD) begin
            $display("FAIL tmo_pred_hold: got %0d/%0d want 1/-3", pred_class, $signed(pred_score)); fails++;
        end
        load_words(5, 0, 1);
        tests += 1;
        if (error !== 1'b0 || host_wr_ready !== 1'b1) begin
            $display("FAIL tmo_clear: got error=%b ready=%b want 0/1", error, host_wr_ready); fails++;
        end
    endtask

    task automatic test_reset_mid_wait();
        load_words(5, 1, N_WORDS - 1);
        accel_ready = 1'b0;
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        tests += 1;
        if (dut.state !== WAIT || busy !== 1'b1) begin
            $display("FAIL pre_reset_wait: got state=%0d busy=%b want WAIT/1", dut.state, busy); fails++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests += 6;
        if (dut.state !== IDLE)   begin $display("FAIL mid_rst_state: got %0d want IDLE", dut.state); fails++; end
        if (dut.wcnt !== '0)      begin $display("FAIL mid_rst_wcnt: got %0d want 0", dut.wcnt); fails++; end
        if (busy !== 1'b0 || accel_reset !== 1'b0) begin
            $display("FAIL mid_rst_busy: got busy=%b accel_reset=%b want 0/0", busy, accel_reset); fails++;
        end
        if (accel_image !== '0)   begin $display("FAIL mid_rst_image: buffer not zero"); fails++; end
        if (done !== 1'b0 || error !== 1'b0) begin
            $display("FAIL mid_rst_flags: got done=%b error=%b want 0/0", done, error); fails++;
        end
        if (host_wr_ready !== 1'b1 || pred_class !== '0) begin
            $display("FAIL mid_rst_ready: got ready=%b class=%0d want 1/0", host_wr_ready, pred_class); fails++;
        end
    endtask

    initial begin
        reset         = 1'b0;
        host_wr_valid = 1'b0;
        host_wr_data  = '0;
        host_start    = 1'b0;
        accel_ready   = 1'b0;
        accel_results = '0;
        test_reset();
        test_normal();
        test_premature_overflow();
        test_stale_ready();
        test_all_negative();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
